fft_bfly_scheduler: RTL
=======================

// Module: fft_bfly_scheduler
// PURPOSE
//   Sequencer for the in-place radix-2 DIT FFT datapath over the shared X_Re/X_Im sample RAM.
//   - Issues one butterfly per cycle: read addresses i_top/i_bot and a twiddle index.
//   - Issues a matching delayed write-back strobe PIPE_LAT cycles later.
//   - Inserts inter-stage drain gaps so no stage reads data not yet written back.
//   - Sits between the top-level Start/Done control FSM and the butterfly unit.
// PARAMETERS
//   LOG2N     10  log2 of transform size N; legal range 2..12.
//   PIPE_LAT  2   butterfly read-to-result latency in cycles; legal range 1..8.
// PORTS
//   Clk       in   1        single clock; all logic on posedge.
//   Reset     in   1        synchronous, active-high.
//   Start     in   1        start request; sampled only in IDLE.
//   Ack       in   1        clears DONE; sampled only in DONE.
//   i_top     out  LOG2N    butterfly top read address.
//   i_bot     out  LOG2N    butterfly bottom read address.
//   tw_idx    out  LOG2N-1  twiddle ROM index, W_N^tw_idx.
//   rd_valid  out  1        i_top/i_bot/tw_idx valid this cycle.
//   wr_top    out  LOG2N    write-back address for y_top.
//   wr_bot    out  LOG2N    write-back address for y_bot.
//   wr_valid  out  1        write y_top/y_bot to wr_top/wr_bot this cycle.
//   stage     out  4        current stage number, 0..LOG2N-1.
//   Busy      out  1        high in ISSUE or GAP.
//   Done      out  1        high in DONE.
//   state     out  4        one-hot state: IDLE=0100, ISSUE=0010, GAP=1000, DONE=0001.
// BEHAVIOUR
//   Reset values:
//   - state=IDLE; stage=0; butterfly counter b=0.
//   - All outputs 0, except state=4'b0100.
//   - Delay-line valids cleared.
//   Reset mid-operation:
//   - Aborts the transform with no further wr_valid pulses.
//   - RAM contents are undefined-partial.
//   FSM transitions:
//   - IDLE -> ISSUE when Start=1.
//   - ISSUE: rd_valid=1 each cycle; b increments 0..N/2-1.
//     At b=N/2-1 go to GAP, with a gap counter loaded to PIPE_LAT-1.
//   - GAP: rd_valid=0 for exactly PIPE_LAT cycles. Then:
//     - if stage<LOG2N-1: stage+1, b=0, go to ISSUE;
//     - else: go to DONE.
//   - DONE: hold until Ack=1, then go to IDLE. Start is ignored in DONE.
//   - Start while Busy is ignored (no restart).
//   Address generation, stage s, butterfly b:
//   - span = 1<<s; pos = b & (span-1); grp = b >> s.
//   - i_top = (grp << (s+1)) | pos.
//   - i_bot = i_top + span.
//   - tw_idx = pos << (LOG2N-1-s).
//   - All values are unsigned and computed combinationally from registered s and b.
//   - i_bot never wraps: max = N-1.
//   - Inputs to the datapath are bit-reversed; this block does no reordering.
//   Write-back:
//   - {rd_valid, i_top, i_bot} is passed through a PIPE_LAT-deep register delay line.
//     Its output is {wr_valid, wr_top, wr_bot}.
//   - wr_valid therefore pulses N/2 times per stage.
//   - The last write of each stage lands in the final GAP cycle, so the next stage's first read
//     sees committed data. Same-cycle read/write of the same address never occurs.
//   Timing (cycle 0 = cycle in which Start is sampled high in IDLE):
//   - First rd_valid in cycle 1.
//   - Done rises in cycle 1 + LOG2N*(N/2 + PIPE_LAT).
//   Outputs:
//   - All outputs are registered or decoded from registered state only.
//   - No Start/Ack input reaches an output combinationally.
// CONFIGURATION
//   Macro FFT_SCHED_HOLD_EN.
//   Defined:
//   - Adds input port "Hold  in  1" after Ack.
//   - While Hold=1 the following are frozen: b, stage, gap counter, FSM and the delay line.
//   - rd_valid and wr_valid are forced 0 while Hold=1.
//   - Delayed entries are preserved and emerge after release.
//   - Total latency grows by the number of held cycles during Busy.
//   - Hold is ignored in IDLE and DONE.
//   Undefined:
//   - No Hold port; behaviour identical to Hold tied 0.
// TESTING
//   Scenario 1, LOG2N=3, PIPE_LAT=2: Reset, then Start pulse.
//   - Stage0 pairs (0,1)(2,3)(4,5)(6,7), tw 0,0,0,0.
//   - Stage1 pairs (0,2)(1,3)(4,6)(5,7), tw 0,2,0,2.
//   - Stage2 pairs (0,4)(1,5)(2,6)(3,7), tw 0,1,2,3.
//   - Done rises in cycle 19.
//   Scenario 2, same config: wr_valid/wr_top/wr_bot equal rd_valid/i_top/i_bot delayed exactly
//   2 cycles. Exactly 12 write pulses; last in cycle 18.
//   Scenario 3, defaults LOG2N=10, PIPE_LAT=2:
//   - Done in cycle 5141.
//   - Every address 0..1023 is written exactly once per stage (scoreboard).
//   Scenario 4: Start held high through Busy and DONE.
//   - No restart; Done stays high.
//   - Ack=1 -> IDLE; Start still high -> new run begins next cycle.
//   Scenario 5: Reset asserted in stage 1, b=2.
//   - Next cycle: state=0100, rd_valid=0, wr_valid=0.
//   - No further writes; a fresh Start gives the nominal 19-cycle run (LOG2N=3, PIPE_LAT=2).
//   Scenario 6, FFT_SCHED_HOLD_EN: Hold=1 for 5 cycles mid-stage-1.
//   - Address sequence unchanged; no valids while held.
//   - Done in cycle 24 (LOG2N=3, PIPE_LAT=2).

Source files
------------

// File: rtl/fft_bfly_scheduler_if.sv
// ---------------------------------------------------------------------------
// fft_bfly_scheduler_if
// Bundles the control handshake (Start/Ack/optional Hold) and the
// read/write-back address buses of the FFT butterfly scheduler.
//
// Parameters
//   LOG2N   log2 of the transform size; sets the address widths.
//
// Signals
//   Start, Ack   control requests from the top-level Start/Done FSM
//   Hold         pipeline freeze (present only with FFT_SCHED_HOLD_EN)
//   i_top/i_bot  butterfly read addresses, tw_idx twiddle index, rd_valid
//   wr_top/wr_bot/wr_valid  delayed write-back strobe and addresses
//   stage, Busy, Done, state  status outputs
//
// Modports
//   master  the controller/datapath side: drives Start/Ack/Hold
//   slave   the scheduler itself: drives every address and status signal
//
// Configuration macro: FFT_SCHED_HOLD_EN adds the Hold signal.
// ---------------------------------------------------------------------------
interface fft_bfly_scheduler_if #(
   parameter int LOG2N = 10
) ();

   logic             Start;
   logic             Ack;
`ifdef FFT_SCHED_HOLD_EN
   logic             Hold;
`endif
   logic [LOG2N-1:0] i_top;
   logic [LOG2N-1:0] i_bot;
   logic [LOG2N-2:0] tw_idx;
   logic             rd_valid;
   logic [LOG2N-1:0] wr_top;
   logic [LOG2N-1:0] wr_bot;
   logic             wr_valid;
   logic [3:0]       stage;
   logic             Busy;
   logic             Done;
   logic [3:0]       state;

`ifdef FFT_SCHED_HOLD_EN
   modport master (
      output Start, Ack, Hold,
      input  i_top, i_bot, tw_idx, rd_valid,
      input  wr_top, wr_bot, wr_valid,
      input  stage, Busy, Done, state
   );

   modport slave (
      input  Start, Ack, Hold,
      output i_top, i_bot, tw_idx, rd_valid,
      output wr_top, wr_bot, wr_valid,
      output stage, Busy, Done, state
   );
`else
   modport master (
      output Start, Ack,
      input  i_top, i_bot, tw_idx, rd_valid,
      input  wr_top, wr_bot, wr_valid,
      input  stage, Busy, Done, state
   );

   modport slave (
      input  Start, Ack,
      output i_top, i_bot, tw_idx, rd_valid,
      output wr_top, wr_bot, wr_valid,
      output stage, Busy, Done, state
   );
`endif

endinterface

// File: rtl/fft_bfly_scheduler.sv
// ---------------------------------------------------------------------------
// fft_bfly_scheduler
// Sequencer for an in-place radix-2 DIT FFT over a shared sample RAM.
// Issues one butterfly (two read addresses plus a twiddle index) per cycle,
// replays each issued butterfly as a write-back strobe PIPE_LAT cycles later,
// and inserts a PIPE_LAT-cycle drain gap after every stage so the next stage
// never reads a location whose result is still in flight.
//
// Parameters
//   LOG2N     log2 of transform size N (2..12)
//   PIPE_LAT  butterfly read-to-result latency in cycles (1..8)
//
// Ports
//   Clk    clock, everything on posedge
//   Reset  synchronous active-high reset
//   bus    fft_bfly_scheduler_if.slave:
//            in : Start (sampled in IDLE), Ack (sampled in DONE), Hold
//            out: i_top, i_bot, tw_idx, rd_valid,
//                 wr_top, wr_bot, wr_valid,
//                 stage, Busy, Done, state (one-hot)
//
// Configuration macro: FFT_SCHED_HOLD_EN
//   When defined, Hold=1 during ISSUE/GAP freezes the butterfly counter,
//   stage, gap counter, FSM and write-back delay line, and masks rd_valid
//   and wr_valid. When undefined the block behaves as if Hold were tied 0.
// ---------------------------------------------------------------------------
module fft_bfly_scheduler #(
   parameter int LOG2N    = 10,
   parameter int PIPE_LAT = 2
) (
   input  logic                Clk,
   input  logic                Reset,
   fft_bfly_scheduler_if.slave bus
);

   localparam int BW = LOG2N - 1;

   // One-hot encodings are visible on the state port, so keep them fixed.
   localparam logic [3:0] S_IDLE  = 4'b0100;
   localparam logic [3:0] S_ISSUE = 4'b0010;
   localparam logic [3:0] S_GAP   = 4'b1000;
   localparam logic [3:0] S_DONE  = 4'b0001;

   localparam logic [BW-1:0] B_LAST     = '1;
   localparam logic [3:0]    STAGE_LAST = 4'(LOG2N - 1);
   localparam logic [2:0]    GAP_LOAD   = 3'(PIPE_LAT - 1);

   logic [3:0]       state_q, state_d;
   logic [3:0]       stage_q, stage_d;
   logic [BW-1:0]    b_q, b_d;
   logic [2:0]       gap_q, gap_d;

   logic             issue;
   logic             busy;
   logic             hold;

   logic [LOG2N-1:0] b_ext;
   logic [LOG2N-1:0] span;
   logic [LOG2N-1:0] pos;
   logic [LOG2N-1:0] grp;
   logic [LOG2N-1:0] addr_top;
   logic [LOG2N-1:0] addr_bot;
   logic [3:0]       tw_shift;
   logic [BW-1:0]    tw_val;

   logic             rd_valid;
   logic [LOG2N-1:0] rd_top;
   logic [LOG2N-1:0] rd_bot;
   logic [BW-1:0]    rd_tw;

   logic             dl_valid_q [PIPE_LAT];
   logic             dl_valid_d [PIPE_LAT];
   logic [LOG2N-1:0] dl_top_q   [PIPE_LAT];
   logic [LOG2N-1:0] dl_top_d   [PIPE_LAT];
   logic [LOG2N-1:0] dl_bot_q   [PIPE_LAT];
   logic [LOG2N-1:0] dl_bot_d   [PIPE_LAT];

   assign issue = (state_q == S_ISSUE);
   assign busy  = issue | (state_q == S_GAP);

   // Hold only has an effect while a transform is running; in IDLE and DONE
   // it is ignored so it can never block Start or Ack.
`ifdef FFT_SCHED_HOLD_EN
   assign hold = bus.Hold & busy;
`else
   assign hold = 1'b0;
`endif

   // Control FSM. b walks the N/2 butterflies of a stage, then the gap
   // counter covers exactly PIPE_LAT drain cycles (loaded with PIPE_LAT-1
   // and counted down to zero) before the next stage or DONE.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      b_d     = b_q;
      gap_d   = gap_q;
      if (!hold) begin
         case (state_q)
            S_IDLE: begin
               if (bus.Start) begin
                  state_d = S_ISSUE;
                  stage_d = '0;
                  b_d     = '0;
               end
            end
            S_ISSUE: begin
               if (b_q == B_LAST) begin
                  state_d = S_GAP;
                  gap_d   = GAP_LOAD;
               end else begin
                  b_d = b_q + BW'(1);
               end
            end
            S_GAP: begin
               if (gap_q == 3'd0) begin
                  if (stage_q == STAGE_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     state_d = S_ISSUE;
                     stage_d = stage_q + 4'd1;
                     b_d     = '0;
                  end
               end else begin
                  gap_d = gap_q - 3'd1;
               end
            end
            S_DONE: begin
               if (bus.Ack) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Butterfly addressing for stage s: b splits into a group number (upper
   // bits) and a position inside the group (low s bits). Inserting a zero
   // bit at position s gives the top index; the bottom partner sits span
   // above it. The twiddle exponent is the position scaled up to the
   // N-point twiddle table.
   always_comb begin
      b_ext    = LOG2N'(b_q);
      span     = LOG2N'(1) << stage_q;
      pos      = b_ext & (span - LOG2N'(1));
      grp      = b_ext >> stage_q;
      addr_top = (grp << (stage_q + 4'd1)) | pos;
      addr_bot = addr_top + span;
      tw_shift = STAGE_LAST - stage_q;
      tw_val   = BW'(pos) << tw_shift;
   end

   // Read-side outputs are zeroed outside ISSUE so the bus idles at zero
   // after reset and during the drain gaps.
   always_comb begin
      rd_valid = issue & ~hold;
      rd_top   = issue ? addr_top : '0;
      rd_bot   = issue ? addr_bot : '0;
      rd_tw    = issue ? tw_val   : '0;
   end

   // Write-back delay line: entry 0 captures the current read, the last
   // entry is the write-back strobe. Freezing the whole line on Hold keeps
   // in-flight butterflies aligned with the frozen datapath.
   always_comb begin
      for (int i = 0; i < PIPE_LAT; i++) begin
         dl_valid_d[i] = dl_valid_q[i];
         dl_top_d[i]   = dl_top_q[i];
         dl_bot_d[i]   = dl_bot_q[i];
      end
      if (!hold) begin
         dl_valid_d[0] = rd_valid;
         dl_top_d[0]   = rd_top;
         dl_bot_d[0]   = rd_bot;
         for (int i = 1; i < PIPE_LAT; i++) begin
            dl_valid_d[i] = dl_valid_q[i-1];
            dl_top_d[i]   = dl_top_q[i-1];
            dl_bot_d[i]   = dl_bot_q[i-1];
         end
      end
   end

   // State registers. Reset also empties the delay line so an aborted
   // transform produces no further write strobes.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_IDLE;
         stage_q <= '0;
         b_q     <= '0;
         gap_q   <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            dl_valid_q[i] <= 1'b0;
            dl_top_q[i]   <= '0;
            dl_bot_q[i]   <= '0;
         end
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         b_q     <= b_d;
         gap_q   <= gap_d;
         for (int i = 0; i < PIPE_LAT; i++) begin
            dl_valid_q[i] <= dl_valid_d[i];
            dl_top_q[i]   <= dl_top_d[i];
            dl_bot_q[i]   <= dl_bot_d[i];
         end
      end
   end

   // Output mapping; everything here derives from registered state.
   always_comb begin
      bus.i_top    = rd_top;
      bus.i_bot    = rd_bot;
      bus.tw_idx   = rd_tw;
      bus.rd_valid = rd_valid;
      bus.wr_top   = dl_top_q[PIPE_LAT-1];
      bus.wr_bot   = dl_bot_q[PIPE_LAT-1];
      bus.wr_valid = dl_valid_q[PIPE_LAT-1] & ~hold;
      bus.stage    = stage_q;
      bus.Busy     = busy;
      bus.Done     = (state_q == S_DONE);
      bus.state    = state_q;
   end

endmodule
